// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NREQ requesters, up to BURST_MAX words per grant.
// One cycle of arbitration in IDLE; wfull stalls the owner in place without losing the grant.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int BURST_MAX = 16
) (
  input  logic                    wclk,
  input  logic                    wrst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_last,
  input  logic [NREQ*DSIZE-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    wfull,
  output logic                    winc,
  output logic [DSIZE-1:0]        wdata,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic [15:0]             wr_count
);
  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(BURST_MAX + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [IW-1:0] owner;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] pick;
  logic          pick_vld;
  logic [BW-1:0] burst_cnt;
  logic          in_busy;
  logic          xfer;
  logic          release_now;

  // Scan downward from the farthest slot so the last hit is the one nearest rr_ptr.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = rr_ptr;
    pick_vld = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % NREQ;
      if (req_valid[idx]) begin
        pick     = IW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign in_busy     = (state == BUSY) && !wrst;
  assign xfer        = in_busy && req_valid[owner] && !wfull;
  assign release_now = req_last[owner] || (burst_cnt == BW'(BURST_MAX - 1));

  assign winc     = xfer;
  assign busy     = in_busy;
  assign grant_id = wrst ? '0 : owner;
  assign wdata    = in_busy ? req_data[owner*DSIZE +: DSIZE] : '0;

  always_comb begin
    req_ready = '0;
    if (in_busy && !wfull) req_ready[owner] = 1'b1;
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      wr_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            owner     <= pick;
            burst_cnt <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (xfer) begin
            burst_cnt <= burst_cnt + 1'b1;
            if (release_now) begin
              state  <= IDLE;
              rr_ptr <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
      if (xfer && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: requester queues feed the DUT, a scoreboard checks every FIFO write.
// A second instance with long bursts drives wr_count into saturation.
module tb_fifo_wr_arbiter;
  logic        wclk = 1'b0;
  logic        wrst;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic        wfull, winc, busy;
  logic [7:0]  wdata;
  logic [1:0]  grant_id;
  logic [15:0] wr_count;

  logic [1:0]  s_valid, s_last, s_ready;
  logic [15:0] s_data;
  logic        s_winc, s_busy;
  logic [7:0]  s_wdata;
  logic [0:0]  s_gid;
  logic [15:0] s_count;

  int checks = 0;
  int errors = 0;

  logic [8:0] src [4][$];   // per requester: {last, data}
  logic [9:0] exp_q [$];    // expected writes: {grant_id, data}
  logic [3:0] acc;

  fifo_wr_arbiter #(.NREQ(4), .DSIZE(8), .BURST_MAX(16)) dut (
    .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .wfull(wfull), .winc(winc),
    .wdata(wdata), .busy(busy), .grant_id(grant_id), .wr_count(wr_count)
  );

  fifo_wr_arbiter #(.NREQ(2), .DSIZE(8), .BURST_MAX(256)) dut_sat (
    .wclk(wclk), .wrst(wrst), .req_valid(s_valid), .req_last(s_last),
    .req_data(s_data), .req_ready(s_ready), .wfull(1'b0), .winc(s_winc),
    .wdata(s_wdata), .busy(s_busy), .grant_id(s_gid), .wr_count(s_count)
  );

  always #5 wclk = ~wclk;

  function automatic logic [8:0] w(input bit l, input int d);
    return {l, d[7:0]};
  endfunction

  function automatic logic [9:0] e(input int id, input int d);
    return {id[1:0], d[7:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic apply_drive();
    for (int i = 0; i < 4; i++) begin
      if (src[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_last[i]        = src[i][0][8];
        req_data[i*8 +: 8] = src[i][0][7:0];
      end else begin
        req_valid[i]       = 1'b0;
        req_last[i]        = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
      end
    end
  endtask

  // One clock: sample before the edge, retire accepted words after it, return at the negedge.
  task automatic tick();
    logic [9:0] ev;
    apply_drive();
    #1;
    acc = req_valid & req_ready;
    check("winc_while_full", winc & wfull, 0);
    if (winc === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL extra_write: observed id=%0d data=%0h, expected no write", grant_id, wdata);
      end
      if (exp_q.size() != 0) begin
        ev = exp_q.pop_front();
        check("write_word", {22'd0, grant_id, wdata}, {22'd0, ev});
      end
    end
    @(posedge wclk);
    #1;
    for (int i = 0; i < 4; i++)
      if (acc[i] && src[i].size() > 0) void'(src[i].pop_front());
    apply_drive();
    @(negedge wclk);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 4; i++) src[i].delete();
    exp_q.delete();
    wrst = 1'b1;
    tick();
    tick();
    wrst = 1'b0;
    #1;
  endtask

  initial begin
    int n, guard;
    bit seen34, seen35;
    wrst = 1'b1; wfull = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0;
    s_valid = '0; s_last = '0; s_data = 16'h5AA5;

    // Reset with a requester already valid: nothing may move.
    src[2].push_back(w(1, 8'hEE));
    tick();
    check("rst_busy", busy, 0);
    check("rst_winc", winc, 0);
    check("rst_ready", req_ready, 0);
    check("rst_wdata", wdata, 0);
    check("rst_grant", grant_id, 0);
    tick();
    check("rst_count", wr_count, 0);
    wrst = 1'b0;
    exp_q.push_back(e(2, 8'hEE));
    drain("rst_pre", 10);

    // Single 3-word packet from requester 0.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      src[0].push_back(w(k == 2, 8'h10 + k));
      exp_q.push_back(e(0, 8'h10 + k));
    end
    tick();
    check("A_busy_rise", busy, 1);
    check("A_grant", grant_id, 0);
    check("A_winc0", winc, 1);
    tick();
    check("A_winc1", winc, 1);
    tick();
    check("A_winc2", winc, 1);
    tick();
    check("A_release", busy, 0);
    check("A_winc_idle", winc, 0);
    check("A_count", wr_count, 3);
    // rr_ptr is now 1: requester 1 beats requester 0.
    src[0].push_back(w(1, 8'h20));
    src[1].push_back(w(1, 8'h21));
    exp_q.push_back(e(1, 8'h21));
    exp_q.push_back(e(0, 8'h20));
    tick();
    check("A_rr_ptr", grant_id, 1);
    drain("A", 20);

    // Four 1-word requesters: strict rotation with an IDLE gap after each grant.
    do_reset();
    src[0].push_back(w(1, 8'h30));
    src[0].push_back(w(1, 8'h34));
    src[1].push_back(w(1, 8'h31));
    src[2].push_back(w(1, 8'h32));
    src[3].push_back(w(1, 8'h33));
    exp_q.push_back(e(0, 8'h30));
    exp_q.push_back(e(1, 8'h31));
    exp_q.push_back(e(2, 8'h32));
    exp_q.push_back(e(3, 8'h33));
    exp_q.push_back(e(0, 8'h34));
    for (int k = 0; k < 10; k++) begin
      tick();
      check("B_busy_pattern", busy, (k % 2 == 0) ? 1 : 0);
      if (k % 2 == 0) check("B_grant_order", grant_id, (k / 2) % 4);
    end
    drain("B", 10);
    check("B_count", wr_count, 5);

    // 40-word stream from requester 2 cut into 16-word bursts.
    do_reset();
    for (int k = 0; k < 40; k++) src[2].push_back(w(k == 39, 8'h40 + k));
    for (int k = 0; k < 16; k++) exp_q.push_back(e(2, 8'h40 + k));
    exp_q.push_back(e(3, 8'hA3));
    exp_q.push_back(e(0, 8'hA0));
    for (int k = 16; k < 40; k++) exp_q.push_back(e(2, 8'h40 + k));
    tick();
    check("C_grant", grant_id, 2);
    src[3].push_back(w(1, 8'hA3));
    src[0].push_back(w(1, 8'hA0));
    repeat (16) tick();
    check("C_burst_release", busy, 0);
    tick();
    check("C_next_grant", grant_id, 3);
    drain("C", 100);
    check("C_count", wr_count, 42);

    // wfull stall for 5 cycles in the middle of a burst.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      src[1].push_back(w(k == 9, 8'h70 + k));
      exp_q.push_back(e(1, 8'h70 + k));
    end
    repeat (4) tick();
    wfull = 1'b1;
    #1;
    check("D_stall_winc0", winc, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("D_stall_winc", winc, 0);
      check("D_stall_ready", req_ready, 0);
      check("D_stall_owner", {busy, grant_id}, 3'b101);
      check("D_stall_count", wr_count, 3);
    end
    wfull = 1'b0;
    #1;
    check("D_resume_winc", winc, 1);
    check("D_resume_data", wdata, 8'h73);
    drain("D", 30);
    check("D_count", wr_count, 10);

    // Reset on the second word of a burst from requester 3.
    do_reset();
    for (int k = 0; k < 4; k++) src[3].push_back(w(k == 3, 8'h80 + k));
    exp_q.push_back(e(3, 8'h80));
    tick();
    tick();
    wrst = 1'b1;
    src[1].push_back(w(1, 8'h91));
    #1;
    check("E_rst_winc", winc, 0);
    check("E_rst_ready", req_ready, 0);
    tick();
    wrst = 1'b0;
    #1;
    check("E_busy", busy, 0);
    check("E_winc", winc, 0);
    check("E_count", wr_count, 0);
    exp_q.push_back(e(1, 8'h91));
    for (int k = 1; k < 4; k++) exp_q.push_back(e(3, 8'h80 + k));
    tick();
    check("E_regrant", {busy, grant_id}, 3'b101);
    drain("E", 30);
    check("E_count_after", wr_count, 4);

    // Saturation of wr_count on the long-burst instance.
    n = 0; guard = 0; seen34 = 0; seen35 = 0;
    s_valid = 2'b01;
    while (n < 65537 && guard < 70000) begin
      @(negedge wclk);
      #1;
      guard++;
      if (n == 65534 && !seen34) begin seen34 = 1; check("sat_fffe", s_count, 16'hFFFE); end
      if (n == 65535 && !seen35) begin seen35 = 1; check("sat_ffff", s_count, 16'hFFFF); end
      if (s_winc) n++;
    end
    @(posedge wclk);
    #1;
    s_valid = 2'b00;
    @(negedge wclk);
    #1;
    check("sat_transfers", n, 65537);
    check("sat_hold", s_count, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the FIFO write port (2..8).
REQ-002 Parameter DSIZE, default 8: data word width.
REQ-003 Parameter BURST_MAX, default 16: maximum words per grant (1..256).
REQ-004 wclk  input  1  write-domain clock; all logic on its rising edge.
REQ-005 wrst  input  1  reset, synchronous and active-high.
REQ-006 req_valid  input  NREQ  per-requester word-valid.
REQ-007 req_last  input  NREQ  per-requester end-of-packet marker, qualified by req_valid.
REQ-008 req_data  input  NREQ*DSIZE  requester i data in bits [i*DSIZE +: DSIZE].
REQ-009 req_ready  output  NREQ  per-requester word accepted this cycle.
REQ-010 wfull  input  1  FIFO full flag, write domain.
REQ-011 winc  output  1  FIFO write strobe.
REQ-012 wdata  output  DSIZE  FIFO write data.
REQ-013 busy  output  1  high while a grant is held.
REQ-014 grant_id  output  $clog2(NREQ)  current owner index; valid when busy=1.
REQ-015 wr_count  output  16  total words written since reset; saturates at 16'hFFFF.

Function
REQ-016 FSM states: IDLE and BUSY only.
REQ-017 IDLE: if any req_valid is high, owner = first set bit scanning upward from rr_ptr, wrapping modulo NREQ; register owner, clear burst counter, go to BUSY next cycle (1-cycle arbitration latency).
REQ-018 IDLE with no req_valid: stay in IDLE; owner and rr_ptr unchanged.
REQ-019 BUSY: winc = req_valid[owner] & ~wfull, combinational.
REQ-020 req_ready[owner] = (state==BUSY) & ~wfull; all other req_ready bits are 0.
REQ-021 wdata = req_data slice of owner whenever state==BUSY; 0 in IDLE.
REQ-022 A transfer occurs on a cycle with winc=1; burst counter increments by 1 and wr_count increments (saturating) on each transfer.
REQ-023 wfull=1 in BUSY: no transfer, ownership held, counter unchanged; no word is dropped or duplicated.
REQ-024 req_valid[owner] low in BUSY: ownership held (packet lock), no transfer.
REQ-025 Release occurs on a transfer with req_last[owner]=1, or on the transfer that brings the burst counter to BURST_MAX, whichever comes first.
REQ-026 On release: state goes to IDLE, and rr_ptr = (owner+1) mod NREQ.
REQ-027 No back-to-back grant: IDLE lasts at least one cycle after every release.
REQ-028 BURST_MAX release without req_last: the requester re-arbitrates for the remainder of its packet at equal priority.
REQ-029 The burst counter is wide enough to hold BURST_MAX without wrap.
REQ-030 winc is never asserted while wfull=1 or in IDLE.

Reset
REQ-031 wrst=1 at a clock edge forces: state=IDLE, rr_ptr=0, owner=0, burst counter=0, wr_count=0.
REQ-032 Outputs during and after reset: busy=0, grant_id=0, winc=0, req_ready=0, wdata=0.
REQ-033 Reset mid-burst: the grant is abandoned with no transfer on the reset cycle; arbitration restarts from requester 0.

Verification
REQ-034 Single requester 0 sends 3 words (last on 3rd), wfull=0 -> busy rises 1 cycle after valid; winc high 3 consecutive cycles; then IDLE; wr_count=3; rr_ptr=1.
REQ-035 All 4 requesters valid with 1-word packets -> grants in order 0,1,2,3,0; each grant is 1 transfer followed by 1 IDLE cycle.
REQ-036 Requester 2 streams 40 words with no last, BURST_MAX=16 -> releases after 16 words, re-granted after other pending requesters; total 40 words in order, no loss.
REQ-037 wfull asserted for 5 cycles mid-burst -> winc=0 and req_ready=0 for those 5 cycles, owner unchanged, next word written after wfull drops.
REQ-038 wrst pulsed during the 2nd word of a burst from requester 3 -> busy=0 next cycle, winc=0, wr_count=0; the next grant goes to the lowest-indexed valid requester.
REQ-039 Drive wr_count to 65535 via forced stimulus, then write 2 more words -> wr_count stays 16'hFFFF.
